// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between N_REQ byte producers,
// with optional bursts of up to MAX_BURST bytes per owner before forced rotation.
module uart_tx_arbiter #(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [N_REQ-1:0]   i_req_valid,
   input  logic [8*N_REQ-1:0] i_req_data,
   output logic [N_REQ-1:0]   o_req_ack,
   output logic [N_REQ-1:0]   o_grant,
   output logic [7:0]         o_tx_data,
   output logic               o_tx_start,
   input  logic               i_tx_ready,
   output logic               o_busy
);

   localparam int unsigned IW = $clog2(N_REQ);
   localparam int unsigned BW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT} state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [7:0]       data_q, data_d;
   logic             start_q, start_d;
   logic             busy_q, busy_d;
   logic [BW-1:0]    burst_q, burst_d;
   logic [IW-1:0]    rr_q, rr_d;

   logic [IW-1:0]    rr_win, win;
   logic             rr_found, keep;
   int unsigned      idx;

   // First valid requester strictly after rr_q, wrapping; rr_q itself is checked last.
   always_comb begin
      rr_win   = rr_q;
      rr_found = 1'b0;
      idx      = 0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         idx = (32'(rr_q) + i) % N_REQ;
         if (!rr_found && i_req_valid[IW'(idx)]) begin
            rr_win   = IW'(idx);
            rr_found = 1'b1;
         end
      end
   end

   // The current owner keeps the serializer while it stays valid and has burst budget left.
   assign keep = (|(grant_q & i_req_valid)) && (32'(burst_q) < MAX_BURST);
   assign win  = keep ? rr_q : rr_win;

   always_comb begin
      state_d = state_q;
      ack_d   = '0;
      grant_d = grant_q;
      data_d  = data_q;
      start_d = start_q;
      burst_d = burst_q;
      rr_d    = rr_q;
      unique case (state_q)
         ST_IDLE: begin
            start_d = 1'b0;
            if (i_tx_ready && (|i_req_valid)) begin
               burst_d = keep ? (burst_q + BW'(1)) : BW'(1);
               ack_d   = N_REQ'(1) << win;
               grant_d = N_REQ'(1) << win;
               for (int unsigned k = 0; k < N_REQ; k++) begin
                  if (IW'(k) == win) data_d = i_req_data[8*k +: 8];
               end
               rr_d    = win;
               start_d = 1'b1;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (!i_tx_ready) begin
               start_d = 1'b0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            start_d = 1'b0;
            if (i_tx_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         ack_q   <= '0;
         grant_q <= '0;
         data_q  <= 8'h00;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         burst_q <= '0;
         rr_q    <= IW'(N_REQ - 1);
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         burst_q <= burst_d;
         rr_q    <= rr_d;
      end
   end

   assign o_req_ack  = ack_q;
   assign o_grant    = grant_q;
   assign o_tx_data  = data_q;
   assign o_tx_start = start_q;
   assign o_busy     = busy_q;

endmodule
